// File: rtl/mbinit_repairclk_fsm.sv
// mbinit_repairclk_fsm
// MBINIT.REPAIRCLK substep controller. It runs the sideband init/result/done
// handshake with the partner die around the clock-lane repair pattern. It also
// checks the returned RCKP/RCKN/RTRK lane results.
// Optional feature: define MBINIT_REPAIRCLK_TIMEOUT_EN to build a wait-state
// timeout counter. The counter sends the FSM to ERROR after TIMEOUT_CYCLES
// cycles without progress.
module mbinit_repairclk_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       i_CAL_end,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic [2:0] i_Rx_msginfo,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_CLK_Pattern_done,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic       o_MBINIT_REPAIRCLK_Pattern_En,
  output logic [2:0] o_clk_lane_status,
  output logic       o_REPAIRCLK_end,
  output logic       o_train_error_req
);

  // Sideband message encodings used by this substep.
  localparam logic [3:0] MSG_NONE        = 4'b0000;
  localparam logic [3:0] MSG_INIT_REQ    = 4'b0001;
  localparam logic [3:0] MSG_INIT_RESP   = 4'b0010;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'b0011;
  localparam logic [3:0] MSG_RESULT_RESP = 4'b0100;
  localparam logic [3:0] MSG_DONE_REQ    = 4'b0101;
  localparam logic [3:0] MSG_DONE_RESP   = 4'b0110;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_SEND_INIT      = 4'd1,
    ST_WAIT_INIT      = 4'd2,
    ST_PATTERN        = 4'd3,
    ST_WAIT_BUSY_RES  = 4'd4,
    ST_SEND_RESULT    = 4'd5,
    ST_WAIT_RESULT    = 4'd6,
    ST_CHECK          = 4'd7,
    ST_WAIT_BUSY_DONE = 4'd8,
    ST_SEND_DONE      = 4'd9,
    ST_WAIT_DONE      = 4'd10,
    ST_COMPLETE       = 4'd11,
    ST_ERROR          = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tx_msg_q, tx_msg_d;
  logic       valid_q, valid_d;
  logic       pat_en_q, pat_en_d;
  logic       end_q, end_d;
  logic       err_q, err_d;
  logic [2:0] lane_status_q, lane_status_d;
  logic       timeout_hit;

  // Qualified received messages.
  logic rx_init_resp, rx_result_resp, rx_done_resp;
  assign rx_init_resp   = i_msg_valid && (i_Rx_SbMessage == MSG_INIT_RESP);
  assign rx_result_resp = i_msg_valid && (i_Rx_SbMessage == MSG_RESULT_RESP);
  assign rx_done_resp   = i_msg_valid && (i_Rx_SbMessage == MSG_DONE_RESP);

`ifdef MBINIT_REPAIRCLK_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait;

  assign in_wait = (state_q == ST_WAIT_INIT)   || (state_q == ST_PATTERN) ||
                   (state_q == ST_WAIT_RESULT) || (state_q == ST_WAIT_DONE);
  assign timeout_hit = in_wait && (cnt_q == CNT_LIMIT);

  // Timeout counter: restarts on any state change and in IDLE, counts only in waits.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else if (in_wait) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No counter: waits hold indefinitely. The parameter is still referenced so
  // both builds share one parameter list.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic for the handshake sequence.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can leave
    // it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_CAL_end && !i_Busy_SideBand) state_d = ST_SEND_INIT;
      end
      ST_SEND_INIT: begin
        if (i_falling_edge_busy) state_d = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (rx_init_resp)     state_d = ST_PATTERN;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_PATTERN: begin
        if (i_CLK_Pattern_done) state_d = ST_WAIT_BUSY_RES;
        else if (timeout_hit)   state_d = ST_ERROR;
      end
      ST_WAIT_BUSY_RES: begin
        if (!i_Busy_SideBand) state_d = ST_SEND_RESULT;
      end
      ST_SEND_RESULT: begin
        if (i_falling_edge_busy) state_d = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (rx_result_resp)   state_d = ST_CHECK;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_CHECK: begin
        state_d = (lane_status_q == 3'b111) ? ST_WAIT_BUSY_DONE : ST_ERROR;
      end
      ST_WAIT_BUSY_DONE: begin
        if (!i_Busy_SideBand) state_d = ST_SEND_DONE;
      end
      ST_SEND_DONE: begin
        if (i_falling_edge_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (rx_done_resp)     state_d = ST_COMPLETE;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_COMPLETE: begin
        if (!i_CAL_end) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (!i_CAL_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with state_q.
  always_comb begin
    tx_msg_d = MSG_NONE;
    valid_d  = 1'b0;
    pat_en_d = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_d)
      ST_SEND_INIT:   begin valid_d = 1'b1; tx_msg_d = MSG_INIT_REQ;   end
      ST_SEND_RESULT: begin valid_d = 1'b1; tx_msg_d = MSG_RESULT_REQ; end
      ST_SEND_DONE:   begin valid_d = 1'b1; tx_msg_d = MSG_DONE_REQ;   end
      ST_PATTERN:     pat_en_d = 1'b1;
      ST_COMPLETE:    end_d    = 1'b1;
      ST_ERROR:       err_d    = 1'b1;
      default: ;
    endcase
  end

  // Lane status: cleared when a new attempt starts, captured from result_resp,
  // otherwise held so a failing result stays visible in ERROR.
  always_comb begin
    lane_status_d = lane_status_q;
    if ((state_d == ST_SEND_INIT) && (state_q != ST_SEND_INIT)) begin
      lane_status_d = 3'b000;
    end else if ((state_q == ST_WAIT_RESULT) && rx_result_resp) begin
      lane_status_d = i_Rx_msginfo;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_msg_q      <= MSG_NONE;
      valid_q       <= 1'b0;
      pat_en_q      <= 1'b0;
      end_q         <= 1'b0;
      err_q         <= 1'b0;
      lane_status_q <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments for all state, so every register samples
      // pre-edge values regardless of statement order.
      state_q       <= state_d;
      tx_msg_q      <= tx_msg_d;
      valid_q       <= valid_d;
      pat_en_q      <= pat_en_d;
      end_q         <= end_d;
      err_q         <= err_d;
      lane_status_q <= lane_status_d;
    end
  end

  assign o_TX_SbMessage                = tx_msg_q;
  assign o_ValidOutDatat_Module        = valid_q;
  assign o_MBINIT_REPAIRCLK_Pattern_En = pat_en_q;
  assign o_clk_lane_status             = lane_status_q;
  assign o_REPAIRCLK_end               = end_q;
  assign o_train_error_req             = err_q;

endmodule

// File: tb/tb_mbinit_repairclk_fsm.sv
// tb_mbinit_repairclk_fsm
// Directed bench for mbinit_repairclk_fsm. Inputs change 1 ns after the rising
// edge, and outputs are checked at the same point, away from the edge. The
// timeout section follows MBINIT_REPAIRCLK_TIMEOUT_EN, with TIMEOUT_CYCLES = 16.
module tb_mbinit_repairclk_fsm;

  logic       CLK = 1'b0;
  logic       rst;
  logic       i_CAL_end;
  logic [3:0] i_Rx_SbMessage;
  logic       i_msg_valid;
  logic [2:0] i_Rx_msginfo;
  logic       i_Busy_SideBand;
  logic       i_falling_edge_busy;
  logic       i_CLK_Pattern_done;
  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutDatat_Module;
  logic       o_MBINIT_REPAIRCLK_Pattern_En;
  logic [2:0] o_clk_lane_status;
  logic       o_REPAIRCLK_end;
  logic       o_train_error_req;

  int vectors     = 0;
  int miscompares = 0;

  mbinit_repairclk_fsm #(.TIMEOUT_CYCLES(16)) dut (
    .CLK                           (CLK),
    .rst                           (rst),
    .i_CAL_end                     (i_CAL_end),
    .i_Rx_SbMessage                (i_Rx_SbMessage),
    .i_msg_valid                   (i_msg_valid),
    .i_Rx_msginfo                  (i_Rx_msginfo),
    .i_Busy_SideBand               (i_Busy_SideBand),
    .i_falling_edge_busy           (i_falling_edge_busy),
    .i_CLK_Pattern_done            (i_CLK_Pattern_done),
    .o_TX_SbMessage                (o_TX_SbMessage),
    .o_ValidOutDatat_Module        (o_ValidOutDatat_Module),
    .o_MBINIT_REPAIRCLK_Pattern_En (o_MBINIT_REPAIRCLK_Pattern_En),
    .o_clk_lane_status             (o_clk_lane_status),
    .o_REPAIRCLK_end               (o_REPAIRCLK_end),
    .o_train_error_req             (o_train_error_req)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Compares every output against one expected vector.
  task automatic check_outs(input string tag, input logic vld, input logic [3:0] msg,
                            input logic pat, input logic [2:0] sts,
                            input logic done, input logic err);
    check({tag, ".valid"},  32'(o_ValidOutDatat_Module),        32'(vld));
    check({tag, ".msg"},    32'(o_TX_SbMessage),                32'(msg));
    check({tag, ".pat"},    32'(o_MBINIT_REPAIRCLK_Pattern_En), 32'(pat));
    check({tag, ".status"}, 32'(o_clk_lane_status),             32'(sts));
    check({tag, ".end"},    32'(o_REPAIRCLK_end),               32'(done));
    check({tag, ".err"},    32'(o_train_error_req),             32'(err));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rx(input logic [3:0] msg, input logic [2:0] info);
    i_msg_valid    = 1'b1;
    i_Rx_SbMessage = msg;
    i_Rx_msginfo   = info;
  endtask

  task automatic rx_idle();
    i_msg_valid    = 1'b0;
    i_Rx_SbMessage = 4'b0000;
    i_Rx_msginfo   = 3'b000;
  endtask

  // Drives the sequence from IDLE with CAL_end high up to the PATTERN state.
  task automatic to_pattern(input string tag);
    i_CAL_end = 1'b1; i_Busy_SideBand = 1'b0;
    step();                                            // SEND_INIT
    check_outs({tag, ".send_init"}, 1, 4'b0001, 0, 3'b000, 0, 0);
    i_falling_edge_busy = 1'b1;
    step();                                            // WAIT_INIT
    i_falling_edge_busy = 1'b0;
    rx(4'b0010, 3'b000);
    step();                                            // PATTERN
    rx_idle();
    check_outs({tag, ".pattern"}, 0, 4'b0000, 1, 3'b000, 0, 0);
  endtask

  initial begin
    rst = 1'b1; i_CAL_end = 1'b0; i_Busy_SideBand = 1'b0;
    i_falling_edge_busy = 1'b0; i_CLK_Pattern_done = 1'b0;
    rx_idle();
    step(); step();
    check_outs("reset", 0, 4'b0000, 0, 3'b000, 0, 0);
    rst = 1'b0;
    step();
    check_outs("idle", 0, 4'b0000, 0, 3'b000, 0, 0);

    // ---------------- happy path ----------------
    i_CAL_end = 1'b1;
    step();
    check_outs("hp.send_init", 1, 4'b0001, 0, 3'b000, 0, 0);
    i_Busy_SideBand = 1'b1;
    step();
    check_outs("hp.send_init_hold", 1, 4'b0001, 0, 3'b000, 0, 0);
    i_Busy_SideBand = 1'b0; i_falling_edge_busy = 1'b1;
    step();
    i_falling_edge_busy = 1'b0;
    check_outs("hp.wait_init", 0, 4'b0000, 0, 3'b000, 0, 0);
    rx(4'b0110, 3'b000);                               // stray done_resp
    step();
    check_outs("hp.stray_ignored", 0, 4'b0000, 0, 3'b000, 0, 0);
    rx(4'b0010, 3'b000);
    step();
    rx_idle();
    check_outs("hp.pattern", 0, 4'b0000, 1, 3'b000, 0, 0);
    step();
    check("hp.pattern_held", 32'(o_MBINIT_REPAIRCLK_Pattern_En), 32'd1);
    i_CLK_Pattern_done = 1'b1; i_Busy_SideBand = 1'b1;
    step();
    i_CLK_Pattern_done = 1'b0;
    check_outs("hp.wait_busy_res", 0, 4'b0000, 0, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hp.busy_gate.valid", 32'(o_ValidOutDatat_Module), 32'd0);
    end
    i_Busy_SideBand = 1'b0;
    step();
    check_outs("hp.send_result", 1, 4'b0011, 0, 3'b000, 0, 0);
    i_falling_edge_busy = 1'b1;
    rx(4'b0100, 3'b111);                               // collides with SEND exit: dropped
    step();
    i_falling_edge_busy = 1'b0;
    rx_idle();
    check_outs("hp.wait_result", 0, 4'b0000, 0, 3'b000, 0, 0);
    step();
    check("hp.dropped_resp.status", 32'(o_clk_lane_status), 32'd0);
    rx(4'b0100, 3'b111);
    step();                                            // CHECK
    rx_idle();
    check_outs("hp.check", 0, 4'b0000, 0, 3'b111, 0, 0);
    step();                                            // WAIT_BUSY_DONE
    check_outs("hp.wait_busy_done", 0, 4'b0000, 0, 3'b111, 0, 0);
    step();                                            // SEND_DONE
    check_outs("hp.send_done", 1, 4'b0101, 0, 3'b111, 0, 0);
    i_falling_edge_busy = 1'b1;
    step();
    i_falling_edge_busy = 1'b0;
    check("hp.wait_done.valid", 32'(o_ValidOutDatat_Module), 32'd0);
    rx(4'b0110, 3'b000);
    step();
    rx_idle();
    check_outs("hp.complete", 0, 4'b0000, 0, 3'b111, 1, 0);
    step(); step();
    check("hp.complete_held", 32'(o_REPAIRCLK_end), 32'd1);
    i_CAL_end = 1'b0;
    step();
    check_outs("hp.back_idle", 0, 4'b0000, 0, 3'b111, 0, 0);

    // ---------------- lane failure ----------------
    to_pattern("lf");
    i_CLK_Pattern_done = 1'b1;
    step();                                            // WAIT_BUSY_RES
    i_CLK_Pattern_done = 1'b0;
    step();                                            // SEND_RESULT
    check_outs("lf.send_result", 1, 4'b0011, 0, 3'b000, 0, 0);
    i_falling_edge_busy = 1'b1;
    step();
    i_falling_edge_busy = 1'b0;
    rx(4'b0100, 3'b101);
    step();                                            // CHECK
    rx_idle();
    check_outs("lf.check", 0, 4'b0000, 0, 3'b101, 0, 0);
    step();                                            // ERROR
    check_outs("lf.error", 0, 4'b0000, 0, 3'b101, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("lf.error_held", 0, 4'b0000, 0, 3'b101, 0, 1);
    end
    i_CAL_end = 1'b0;
    step();
    check_outs("lf.back_idle", 0, 4'b0000, 0, 3'b101, 0, 0);

    // ---------------- reset mid-PATTERN, then restart ----------------
    to_pattern("rp");
    rst = 1'b1;
    step();
    check_outs("rp.reset", 0, 4'b0000, 0, 3'b000, 0, 0);
    rst = 1'b0;
    step();                                            // restart: SEND_INIT
    check_outs("rp.restart", 1, 4'b0001, 0, 3'b000, 0, 0);

    // ---------------- timeout from WAIT_INIT ----------------
    i_falling_edge_busy = 1'b1;
    step();                                            // WAIT_INIT entry
    i_falling_edge_busy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("to.before_limit.err", 32'(o_train_error_req), 32'd0);
    end
    step();
`ifdef MBINIT_REPAIRCLK_TIMEOUT_EN
    check_outs("to.error", 0, 4'b0000, 0, 3'b000, 0, 1);
    i_CAL_end = 1'b0;
    step();
    check_outs("to.back_idle", 0, 4'b0000, 0, 3'b000, 0, 0);
`else
    check_outs("to.still_waiting", 0, 4'b0000, 0, 3'b000, 0, 0);
    rx(4'b0010, 3'b000);
    step();
    rx_idle();
    check_outs("to.late_init_resp", 0, 4'b0000, 1, 3'b000, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
